// File: rtl/fetch_queue_if.sv
// fetch_queue_if: IFU-to-decode bundle handshake, flush and status signals for fetch_queue.
// master drives the fetch side and decode ready; slave is the queue itself.
interface fetch_queue_if #(
    parameter int unsigned FETCH_WIDTH     = 2,
    parameter int unsigned INST_ADDR_WIDTH = 32,
    parameter int unsigned DEPTH           = 8
);
    localparam int unsigned INST_W = 32 * FETCH_WIDTH;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic                       in_valid;
    logic [INST_W-1:0]          in_inst;
    logic [INST_ADDR_WIDTH-1:0] in_pc;
    logic [INST_ADDR_WIDTH-1:0] in_pc_plus_4;
    logic                       flush;
    logic                       dec_ready;
    logic                       dec_valid;
    logic [INST_W-1:0]          dec_inst;
    logic [INST_ADDR_WIDTH-1:0] dec_pc;
    logic [INST_ADDR_WIDTH-1:0] dec_pc_plus_4;
    logic                       stall_out;
    logic [CNT_W-1:0]           count;
    logic                       overflow;

    modport master (
        output in_valid, in_inst, in_pc, in_pc_plus_4, flush, dec_ready,
        input  dec_valid, dec_inst, dec_pc, dec_pc_plus_4, stall_out, count, overflow
    );

    modport slave (
        input  in_valid, in_inst, in_pc, in_pc_plus_4, flush, dec_ready,
        output dec_valid, dec_inst, dec_pc, dec_pc_plus_4, stall_out, count, overflow
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: bundle FIFO between IFU and decode with skid-reserved stall and redirect flush.
// Define FETCH_QUEUE_BYPASS_EN for a same-cycle empty-queue bypass from in_* to dec_*.
module fetch_queue #(
    parameter int unsigned FETCH_WIDTH     = 2,
    parameter int unsigned INST_ADDR_WIDTH = 32,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned SKID            = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  q
);
    localparam int unsigned INST_W   = 32 * FETCH_WIDTH;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned STALL_AT = DEPTH - SKID;

    typedef struct packed {
        logic [INST_W-1:0]          inst;
        logic [INST_ADDR_WIDTH-1:0] pc;
        logic [INST_ADDR_WIDTH-1:0] pc_plus_4;
    } bundle_t;

    bundle_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic    stored;
    logic    full;
    logic    bypass;
    logic    bypass_take;
    logic    pop;
    logic    push;
    logic    drop;
    bundle_t in_bundle;
    bundle_t head;

    // Handshake decode; a bypassed-and-consumed bundle never touches storage.
    always_comb begin
        in_bundle.inst      = q.in_inst;
        in_bundle.pc        = q.in_pc;
        in_bundle.pc_plus_4 = q.in_pc_plus_4;
        stored = (count_q != '0);
        full   = (count_q == CNT_W'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = ~stored & q.in_valid & ~q.flush;
`else
        bypass = 1'b0;
`endif
        bypass_take = bypass & q.dec_ready;
        pop  = stored & q.dec_ready & ~q.flush;
        push = q.in_valid & ~q.flush & (~full | pop) & ~bypass_take;
        drop = q.in_valid & ~q.flush & full & ~pop;
        head = bypass ? in_bundle : mem[rd_ptr];
    end

    assign q.dec_valid     = stored | bypass;
    assign q.dec_inst      = head.inst;
    assign q.dec_pc        = head.pc;
    assign q.dec_pc_plus_4 = head.pc_plus_4;
    assign q.stall_out     = (count_q >= CNT_W'(STALL_AT));
    assign q.count         = count_q;
    assign q.overflow      = overflow_q;

    // Pointers, occupancy and sticky overflow; flush wins over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (q.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Bundle storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_bundle;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plus randomized stimulus against a queue-based model of fetch_queue.
// The monitor compares DUT outputs to the model head every cycle; build with FETCH_QUEUE_BYPASS_EN to cover bypass.
module tb_fetch_queue;
    localparam int unsigned FW    = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SKID  = 2;

    typedef struct {
        logic [32*FW-1:0] inst;
        logic [AW-1:0]    pc;
        logic [AW-1:0]    pc4;
    } bundle_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fetch_queue_if #(.FETCH_WIDTH(FW), .INST_ADDR_WIDTH(AW), .DEPTH(DEPTH)) q ();

    fetch_queue #(
        .FETCH_WIDTH(FW), .INST_ADDR_WIDTH(AW), .DEPTH(DEPTH), .SKID(SKID)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    bundle_t     mq[$];
    bit          exp_ovf  = 1'b0;
    logic [AW-1:0] next_pc = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit r, input bit f);
        @(posedge clk);
        #1;
        q.in_valid     = v;
        q.dec_ready    = r;
        q.flush        = f;
        q.in_pc        = next_pc;
        q.in_pc_plus_4 = next_pc + AW'(4);
        q.in_inst      = {$urandom, $urandom};
        if (v) next_pc = next_pc + AW'(4);
    endtask

    // Monitor + model: compare against the expected queue, then advance it by the cycle's handshake.
    bit      byp;
    bit      exp_valid;
    bit      was_full;
    bit      took_head;
    bundle_t exp_head;
    bundle_t inb;
    always @(negedge clk) begin
        if (!reset) begin
            mq.delete();
            exp_ovf = 1'b0;
            check("rst_dec_valid", 128'(q.dec_valid), 128'(0));
            check("rst_count",     128'(q.count),     128'(0));
            check("rst_stall",     128'(q.stall_out), 128'(0));
            check("rst_overflow",  128'(q.overflow),  128'(0));
        end else begin
            inb.inst = q.in_inst;
            inb.pc   = q.in_pc;
            inb.pc4  = q.in_pc_plus_4;
            byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            byp = (mq.size() == 0) && q.in_valid && !q.flush;
`endif
            exp_valid = (mq.size() != 0) || byp;
            check("dec_valid", 128'(q.dec_valid), 128'(exp_valid));
            check("count",     128'(q.count),     128'(mq.size()));
            check("stall_out", 128'(q.stall_out), 128'(mq.size() >= DEPTH - SKID));
            check("overflow",  128'(q.overflow),  128'(exp_ovf));
            if (exp_valid) begin
                exp_head = byp ? inb : mq[0];
                check("dec_pc",        128'(q.dec_pc),        128'(exp_head.pc));
                check("dec_pc_plus_4", 128'(q.dec_pc_plus_4), 128'(exp_head.pc4));
                check("dec_inst",      128'(q.dec_inst),      128'(exp_head.inst));
            end
            if (q.flush) begin
                mq.delete();
            end else begin
                was_full  = (mq.size() == DEPTH);
                took_head = (mq.size() != 0) && q.dec_ready;
                if (took_head) void'(mq.pop_front());
                if (q.in_valid && !(byp && q.dec_ready)) begin
                    if (!was_full || took_head) mq.push_back(inb);
                    else exp_ovf = 1'b1;
                end
            end
        end
    end

    initial begin
        q.in_valid     = 1'b0;
        q.dec_ready    = 1'b0;
        q.flush        = 1'b0;
        q.in_inst      = '0;
        q.in_pc        = '0;
        q.in_pc_plus_4 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Three in-order bundles at pc 0x00/0x04/0x08 with decode always ready.
        repeat (3) drive(1, 1, 0);
        repeat (3) drive(0, 1, 0);

        // Fill to stall threshold, then to full, then one dropped bundle.
        repeat (6) drive(1, 0, 0);
        drive(0, 0, 0);
        check("stall_at_6", 128'(q.stall_out), 128'(1));
        repeat (2) drive(1, 0, 0);
        drive(0, 0, 0);
        check("full_count", 128'(q.count), 128'(DEPTH));
        check("full_no_ovf", 128'(q.overflow), 128'(0));
        drive(1, 0, 0);
        drive(0, 0, 0);
        check("ovf_set", 128'(q.overflow), 128'(1));

        // Push and pop together while full, then drain to 5 and reset asynchronously.
        drive(1, 1, 0);
        repeat (3) drive(0, 1, 0);
        drive(0, 0, 0);
        check("pre_rst_count", 128'(q.count), 128'(5));
        #2 reset = 1'b0;
        #1;
        check("async_rst_count",    128'(q.count),     128'(0));
        check("async_rst_valid",    128'(q.dec_valid), 128'(0));
        check("async_rst_stall",    128'(q.stall_out), 128'(0));
        check("async_rst_overflow", 128'(q.overflow),  128'(0));
        @(posedge clk);
        #1 reset = 1'b1;

        // Flush at count=4 with wr_ptr=6 and a bundle arriving the same cycle.
        repeat (6) drive(1, 0, 0);
        repeat (2) drive(0, 1, 0);
        drive(1, 1, 1);
        drive(0, 0, 0);
        check("flush_count", 128'(q.count), 128'(0));
        check("flush_valid", 128'(q.dec_valid), 128'(0));

        // Twenty push/pop pairs across the pointer wrap.
        repeat (20) drive(1, 1, 0);
        repeat (3) drive(0, 1, 0);

        // Randomized traffic with occasional flushes.
        repeat (500) drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                           $urandom_range(0, 15) == 0);
        repeat (DEPTH + 2) drive(0, 1, 0);
        drive(0, 0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
